// File: rtl/mem_ctrl.sv
// Memory stage of a Y86-64 style pipeline: the M and W registers, the data-memory request decode and the stage status.
// Optional MEM_FWD_EN drives the m_stat/m_valM/m_dstM forwarding taps; when it is undefined they are held at bubble values.
`ifndef DATA_WID
`define DATA_WID 64
`endif

module mem_ctrl (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [2:0]             e_stat,
  input  logic [3:0]             e_icode,
  input  logic                   e_Cnd,
  input  logic [`DATA_WID-1:0]   e_valE,
  input  logic [`DATA_WID-1:0]   e_valA,
  input  logic [3:0]             e_dstE,
  input  logic [3:0]             e_dstM,
  input  logic                   M_stall,
  input  logic                   M_bubble,
  input  logic                   W_stall,
  input  logic                   W_bubble,
  output logic [`DATA_WID-1:0]   mem_addr,
  output logic [`DATA_WID-1:0]   mem_wdata,
  output logic                   mem_write,
  output logic                   mem_read,
  input  logic [`DATA_WID-1:0]   mem_valM,
  input  logic                   dmem_error,
  output logic [2:0]             W_stat,
  output logic [3:0]             W_icode,
  output logic [`DATA_WID-1:0]   W_valE,
  output logic [`DATA_WID-1:0]   W_valM,
  output logic [3:0]             W_dstE,
  output logic [3:0]             W_dstM,
  output logic [2:0]             m_stat,
  output logic [`DATA_WID-1:0]   m_valM,
  output logic [3:0]             m_dstM
);

  localparam logic [2:0] SAOK  = 3'd1;
  localparam logic [2:0] SHLT  = 3'd2;
  localparam logic [2:0] SADR  = 3'd3;
  localparam logic [2:0] SINS  = 3'd4;
  localparam logic [3:0] INOP  = 4'h1;
  localparam logic [3:0] RNONE = 4'hF;

  logic [2:0]           M_stat_q,  M_stat_d;
  logic [3:0]           M_icode_q, M_icode_d;
  logic                 M_Cnd_q,   M_Cnd_d;
  logic [`DATA_WID-1:0] M_valE_q,  M_valE_d;
  logic [`DATA_WID-1:0] M_valA_q,  M_valA_d;
  logic [3:0]           M_dstE_q,  M_dstE_d;
  logic [3:0]           M_dstM_q,  M_dstM_d;

  logic [2:0]           W_stat_q,  W_stat_d;
  logic [3:0]           W_icode_q, W_icode_d;
  logic [`DATA_WID-1:0] W_valE_q,  W_valE_d;
  logic [`DATA_WID-1:0] W_valM_q,  W_valM_d;
  logic [3:0]           W_dstE_q,  W_dstE_d;
  logic [3:0]           W_dstM_q,  W_dstM_d;

  logic                 rd_s;
  logic                 wr_raw_s;
  logic [`DATA_WID-1:0] addr_s;
  logic [2:0]           m_stat_s;
  logic [`DATA_WID-1:0] m_valM_s;
  logic                 w_halted_s;
  logic                 w_hold_s;

  // M register next state: stall beats bubble, otherwise take the execute results.
  always_comb begin
    M_stat_d  = M_stat_q;
    M_icode_d = M_icode_q;
    M_Cnd_d   = M_Cnd_q;
    M_valE_d  = M_valE_q;
    M_valA_d  = M_valA_q;
    M_dstE_d  = M_dstE_q;
    M_dstM_d  = M_dstM_q;
    if (M_stall) begin
      M_stat_d = M_stat_q;
    end else if (M_bubble) begin
      M_stat_d  = SAOK;
      M_icode_d = INOP;
      M_Cnd_d   = 1'b0;
      M_valE_d  = {`DATA_WID{1'b0}};
      M_valA_d  = {`DATA_WID{1'b0}};
      M_dstE_d  = RNONE;
      M_dstM_d  = RNONE;
    end else begin
      M_stat_d  = e_stat;
      M_icode_d = e_icode;
      M_Cnd_d   = e_Cnd;
      M_valE_d  = e_valE;
      M_valA_d  = e_valA;
      M_dstE_d  = e_dstE;
      M_dstM_d  = e_dstM;
    end
  end

  // M register with synchronous reset to the bubble.
  always_ff @(posedge CLK) begin
    if (RST) begin
      M_stat_q  <= SAOK;
      M_icode_q <= INOP;
      M_Cnd_q   <= 1'b0;
      M_valE_q  <= {`DATA_WID{1'b0}};
      M_valA_q  <= {`DATA_WID{1'b0}};
      M_dstE_q  <= RNONE;
      M_dstM_q  <= RNONE;
    end else begin
      M_stat_q  <= M_stat_d;
      M_icode_q <= M_icode_d;
      M_Cnd_q   <= M_Cnd_d;
      M_valE_q  <= M_valE_d;
      M_valA_q  <= M_valA_d;
      M_dstE_q  <= M_dstE_d;
      M_dstM_q  <= M_dstM_d;
    end
  end

  // Memory request decode from the instruction held in M.
  always_comb begin
    rd_s     = 1'b0;
    wr_raw_s = 1'b0;
    addr_s   = {`DATA_WID{1'b0}};
    case (M_icode_q)
      4'h4, 4'h8, 4'hA: begin
        wr_raw_s = 1'b1;
        addr_s   = M_valE_q;
      end
      4'h5: begin
        rd_s   = 1'b1;
        addr_s = M_valE_q;
      end
      4'h9, 4'hB: begin
        rd_s   = 1'b1;
        addr_s = M_valA_q;
      end
      default: begin
        rd_s     = 1'b0;
        wr_raw_s = 1'b0;
        addr_s   = {`DATA_WID{1'b0}};
      end
    endcase
  end

  // A faulted older instruction in W must not let a younger store reach memory.
  assign mem_write = wr_raw_s & (W_stat_q == SAOK);
  assign mem_read  = rd_s;
  assign mem_addr  = addr_s;
  assign mem_wdata = M_valA_q;

  assign m_stat_s = (dmem_error && (rd_s || wr_raw_s)) ? SADR : M_stat_q;
  assign m_valM_s = rd_s ? mem_valM : {`DATA_WID{1'b0}};

`ifdef MEM_FWD_EN
  assign m_stat = m_stat_s;
  assign m_valM = m_valM_s;
  assign m_dstM = M_dstM_q;
`else
  assign m_stat = SAOK;
  assign m_valM = {`DATA_WID{1'b0}};
  assign m_dstM = RNONE;
`endif

  // An exception status freezes W until reset.
  assign w_halted_s = (W_stat_q == SADR) || (W_stat_q == SHLT) || (W_stat_q == SINS);
  assign w_hold_s   = W_stall | w_halted_s;

  // W register next state with the same stall-over-bubble priority as M.
  always_comb begin
    W_stat_d  = W_stat_q;
    W_icode_d = W_icode_q;
    W_valE_d  = W_valE_q;
    W_valM_d  = W_valM_q;
    W_dstE_d  = W_dstE_q;
    W_dstM_d  = W_dstM_q;
    if (w_hold_s) begin
      W_stat_d = W_stat_q;
    end else if (W_bubble) begin
      W_stat_d  = SAOK;
      W_icode_d = INOP;
      W_valE_d  = {`DATA_WID{1'b0}};
      W_valM_d  = {`DATA_WID{1'b0}};
      W_dstE_d  = RNONE;
      W_dstM_d  = RNONE;
    end else begin
      W_stat_d  = m_stat_s;
      W_icode_d = M_icode_q;
      W_valE_d  = M_valE_q;
      W_valM_d  = m_valM_s;
      W_dstE_d  = M_dstE_q;
      W_dstM_d  = M_dstM_q;
    end
  end

  // W register with synchronous reset to the bubble.
  always_ff @(posedge CLK) begin
    if (RST) begin
      W_stat_q  <= SAOK;
      W_icode_q <= INOP;
      W_valE_q  <= {`DATA_WID{1'b0}};
      W_valM_q  <= {`DATA_WID{1'b0}};
      W_dstE_q  <= RNONE;
      W_dstM_q  <= RNONE;
    end else begin
      W_stat_q  <= W_stat_d;
      W_icode_q <= W_icode_d;
      W_valE_q  <= W_valE_d;
      W_valM_q  <= W_valM_d;
      W_dstE_q  <= W_dstE_d;
      W_dstM_q  <= W_dstM_d;
    end
  end

  assign W_stat  = W_stat_q;
  assign W_icode = W_icode_q;
  assign W_valE  = W_valE_q;
  assign W_valM  = W_valM_q;
  assign W_dstE  = W_dstE_q;
  assign W_dstM  = W_dstM_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: hand-computed expectations checked with immediate assertions after each clock edge.
`ifndef DATA_WID
`define DATA_WID 64
`endif

module tb_mem_ctrl;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic [2:0]           e_stat;
  logic [3:0]           e_icode;
  logic                 e_Cnd;
  logic [`DATA_WID-1:0] e_valE, e_valA;
  logic [3:0]           e_dstE, e_dstM;
  logic                 M_stall, M_bubble, W_stall, W_bubble;
  logic [`DATA_WID-1:0] mem_addr, mem_wdata, mem_valM;
  logic                 mem_write, mem_read, dmem_error;
  logic [2:0]           W_stat, m_stat;
  logic [3:0]           W_icode, W_dstE, W_dstM, m_dstM;
  logic [`DATA_WID-1:0] W_valE, W_valM, m_valM;

  int total_cnt = 0;
  int pass_cnt  = 0;

  mem_ctrl dut (
    .CLK(CLK), .RST(RST),
    .e_stat(e_stat), .e_icode(e_icode), .e_Cnd(e_Cnd), .e_valE(e_valE), .e_valA(e_valA),
    .e_dstE(e_dstE), .e_dstM(e_dstM),
    .M_stall(M_stall), .M_bubble(M_bubble), .W_stall(W_stall), .W_bubble(W_bubble),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .mem_valM(mem_valM), .dmem_error(dmem_error),
    .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM),
    .m_stat(m_stat), .m_valM(m_valM), .m_dstM(m_dstM)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_e(input logic [3:0] icode, input logic [63:0] valE, input logic [63:0] valA,
                       input logic [3:0] dstE, input logic [3:0] dstM);
    e_stat  = 3'd1;
    e_icode = icode;
    e_Cnd   = 1'b0;
    e_valE  = valE;
    e_valA  = valA;
    e_dstE  = dstE;
    e_dstM  = dstM;
  endtask

  initial begin
    // Reset with conflicting stall inputs and a live store on the E side.
    RST = 1'b1; M_stall = 1'b1; W_stall = 1'b1; M_bubble = 1'b0; W_bubble = 1'b0;
    mem_valM = 64'h0; dmem_error = 1'b0;
    set_e(4'h4, 64'h55, 64'h66, 4'h2, 4'h3);
    tick();
    tick();
    RST = 1'b0; M_stall = 1'b0; W_stall = 1'b0;
    set_e(4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
    check("rst_W_icode", W_icode, 64'h1);
    check("rst_W_stat",  W_stat,  64'h1);
    check("rst_W_dstE",  W_dstE,  64'hF);
    check("rst_W_dstM",  W_dstM,  64'hF);
    check("rst_W_valE",  W_valE,  64'h0);
    check("rst_mem_write", mem_write, 64'h0);
    check("rst_mem_read",  mem_read,  64'h0);
    check("rst_mem_addr",  mem_addr,  64'h0);

    // rmmovq store
    set_e(4'h4, 64'h10, 64'h1122334455667788, 4'hF, 4'hF);
    tick();
    check("st_mem_write", mem_write, 64'h1);
    check("st_mem_read",  mem_read,  64'h0);
    check("st_mem_addr",  mem_addr,  64'h10);
    check("st_mem_wdata", mem_wdata, 64'h1122334455667788);
    set_e(4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
    tick();
    check("st_W_icode", W_icode, 64'h4);
    check("st_W_valE",  W_valE,  64'h10);
    check("st_W_stat",  W_stat,  64'h1);
    check("nop_mem_write", mem_write, 64'h0);

    // popq read
    set_e(4'hB, 64'h28, 64'h20, 4'h4, 4'h7);
    mem_valM = 64'hAB;
    tick();
    check("pop_mem_read",  mem_read,  64'h1);
    check("pop_mem_write", mem_write, 64'h0);
    check("pop_mem_addr",  mem_addr,  64'h20);
    check("pop_m_stat",    m_stat,    64'h1);
`ifdef MEM_FWD_EN
    check("pop_m_valM", m_valM, 64'hAB);
    check("pop_m_dstM", m_dstM, 64'h7);
`else
    check("pop_m_valM", m_valM, 64'h0);
    check("pop_m_dstM", m_dstM, 64'hF);
`endif
    set_e(4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
    tick();
    check("pop_W_valM",  W_valM,  64'hAB);
    check("pop_W_stat",  W_stat,  64'h1);
    check("pop_W_icode", W_icode, 64'hB);
    check("pop_W_dstE",  W_dstE,  64'h4);
    check("pop_W_dstM",  W_dstM,  64'h7);
    check("pop_W_valE",  W_valE,  64'h28);
    check("nop_m_valM",  m_valM,  64'h0);

    // M stall with bubble asserted: stall wins, M frozen on mrmovq
    set_e(4'h5, 64'h300, 64'h0, 4'hF, 4'h6);
    mem_valM = 64'h77;
    tick();
    check("mr_mem_addr", mem_addr, 64'h300);
    M_stall = 1'b1; M_bubble = 1'b1;
    set_e(4'h4, 64'h999, 64'h1, 4'hF, 4'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_mem_addr", mem_addr, 64'h300);
      check("stall_mem_read", mem_read, 64'h1);
    end
    check("stall_W_icode", W_icode, 64'h5);
    M_stall = 1'b0;
    tick();
    check("bub_mem_addr", mem_addr, 64'h0);
    check("bub_mem_read", mem_read, 64'h0);
    check("bub_W_valM",   W_valM,   64'h77);
    M_bubble = 1'b0;
    set_e(4'h1, 64'h0, 64'h0, 4'hF, 4'hF);

    // W stall with bubble: stall wins; then bubble alone clears W
    W_stall = 1'b1; W_bubble = 1'b1;
    tick();
    check("wstall_W_icode", W_icode, 64'h5);
    W_stall = 1'b0;
    tick();
    check("wbub_W_icode", W_icode, 64'h1);
    check("wbub_W_dstM",  W_dstM,  64'hF);
    W_bubble = 1'b0;

    // Address error on a load, then a store behind it
    set_e(4'h5, 64'h200, 64'h0, 4'hF, 4'h3);
    tick();
    dmem_error = 1'b1;
    #1;
    check("err_mem_read", mem_read, 64'h1);
`ifdef MEM_FWD_EN
    check("err_m_stat", m_stat, 64'h3);
`else
    check("err_m_stat", m_stat, 64'h1);
`endif
    set_e(4'h4, 64'h40, 64'h5, 4'hF, 4'hF);
    tick();
    dmem_error = 1'b0;
    check("err_W_stat", W_stat, 64'h3);
    check("err_W_icode", W_icode, 64'h5);
    check("err_mem_write_masked", mem_write, 64'h0);
    check("err_mem_addr", mem_addr, 64'h40);
    set_e(4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
    W_bubble = 1'b1;
    tick();
    check("hold_W_stat",  W_stat,  64'h3);
    check("hold_W_icode", W_icode, 64'h5);
    check("hold_W_valE",  W_valE,  64'h200);
    W_bubble = 1'b0;

    // Reset mid-operation with a store sitting in M
    set_e(4'h4, 64'h80, 64'h9, 4'hF, 4'hF);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    set_e(4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
    check("rst2_W_stat",    W_stat,    64'h1);
    check("rst2_W_icode",   W_icode,   64'h1);
    check("rst2_mem_write", mem_write, 64'h0);
    check("rst2_mem_addr",  mem_addr,  64'h0);

    // Release from the exception: stores allowed again
    set_e(4'hA, 64'h18, 64'hCAFE, 4'h4, 4'hF);
    tick();
    check("push_mem_write", mem_write, 64'h1);
    check("push_mem_addr",  mem_addr,  64'h18);
    check("push_mem_wdata", mem_wdata, 64'hCAFE);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
